// File: rtl/queue_pkg.sv
// Shared sizing and payload type for the 2-entry, 412-bit decoupling queue.
package queue_pkg;
    localparam int QUEUE_WIDTH = 412;
    localparam int QUEUE_DEPTH = 2;
    localparam int PTR_W       = $clog2(QUEUE_DEPTH);
    localparam int CNT_W       = $clog2(QUEUE_DEPTH + 1);

    typedef logic [QUEUE_WIDTH-1:0] payload_t;
endpackage

// File: rtl/ram_2x412.sv
// 2x412 storage: one clocked write port, one combinational read port.
// Write lands on the rising edge; read data follows R0_addr in the same cycle.
module ram_2x412
    import queue_pkg::*;
(
    input  logic           R0_clk,
    input  logic [0:0]     R0_addr,
    input  logic           R0_en,
    output payload_t       R0_data,
    input  logic           W0_clk,
    input  logic [0:0]     W0_addr,
    input  logic           W0_en,
    input  payload_t       W0_data
);
    payload_t mem [2];

    // Read port is asynchronous, so its clock only exists for port compatibility.
    logic unused_r0_clk;
    assign unused_r0_clk = R0_clk;

    always_ff @(posedge W0_clk) begin
        if (W0_en) begin
            mem[W0_addr] <= W0_data;
        end
    end

    assign R0_data = R0_en ? mem[R0_addr] : '0;
endmodule

// File: rtl/queue_2x412.sv
// Ready/valid FIFO controller over ram_2x412; enq->deq latency 1 cycle (0 with FLOW bypass).
// Backpressure: enq_ready drops when full (unless PIPE and deq_ready); all outputs combinational.
module queue_2x412
    import queue_pkg::*;
#(
    parameter int WIDTH = QUEUE_WIDTH,
    parameter int DEPTH = QUEUE_DEPTH,
    parameter bit FLOW  = 1'b0,
    parameter bit PIPE  = 1'b0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_enq_valid,
    output logic                       io_enq_ready,
    input  logic [WIDTH-1:0]           io_enq_bits,
    output logic                       io_deq_valid,
    input  logic                       io_deq_ready,
    output logic [WIDTH-1:0]           io_deq_bits,
    output logic [$clog2(DEPTH+1)-1:0] io_count,
    input  logic                       io_flush
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    enq_ptr;
    logic [PW-1:0]    deq_ptr;
    logic             maybe_full;
    logic             ptr_match;
    logic             empty;
    logic             full;
    logic             enq_fire;
    logic             deq_fire;
    logic             bypass;
    logic             do_enq;
    logic             do_deq;
    logic [PW-1:0]    ptr_diff;
    logic [WIDTH-1:0] r0_data;

    assign ptr_match = (enq_ptr == deq_ptr);
    assign empty     = ptr_match & ~maybe_full;
    assign full      = ptr_match & maybe_full;

    assign io_enq_ready = ~full | (PIPE & io_deq_ready);
    assign io_deq_valid = ~empty | (FLOW & io_enq_valid);

    assign enq_fire = io_enq_valid & io_enq_ready;
    assign deq_fire = io_deq_valid & io_deq_ready;

    // An empty FLOW queue hands the payload straight through without touching storage.
    assign bypass = FLOW & empty & enq_fire & deq_fire;
    assign do_enq = enq_fire & ~bypass;
    assign do_deq = deq_fire & ~bypass;

    assign io_deq_bits = bypass ? io_enq_bits : r0_data;

    assign ptr_diff = enq_ptr - deq_ptr;
    assign io_count = full ? CW'(DEPTH) : {{(CW-PW){1'b0}}, ptr_diff};

    always_ff @(posedge clock) begin
        if (reset || io_flush) begin
            enq_ptr    <= '0;
            deq_ptr    <= '0;
            maybe_full <= 1'b0;
        end else begin
            if (do_enq) begin
                enq_ptr <= enq_ptr + 1'b1;
            end
            if (do_deq) begin
                deq_ptr <= deq_ptr + 1'b1;
            end
            if (do_enq != do_deq) begin
                maybe_full <= do_enq;
            end
        end
    end

    ram_2x412 u_ram (
        .R0_clk  (clock),
        .R0_addr (deq_ptr),
        .R0_en   (1'b1),
        .R0_data (r0_data),
        .W0_clk  (clock),
        .W0_addr (enq_ptr),
        .W0_en   (do_enq),
        .W0_data (io_enq_bits)
    );
endmodule

// File: tb/tb_queue_2x412.sv
// Scoreboard bench driving a plain queue and a FLOW+PIPE queue with shared stimulus.
module tb_queue_2x412;
    import queue_pkg::*;

    localparam int W = QUEUE_WIDTH;

    logic         clock = 1'b0;
    logic         reset;
    logic         enq_valid;
    logic         deq_ready;
    logic         flush;
    logic [W-1:0] enq_bits;

    logic         enq_rdy  [2];
    logic         deq_vld  [2];
    logic [W-1:0] deq_bits [2];
    logic [1:0]   cnt      [2];

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;
    bit pushed [2];

    logic [W-1:0] sb0 [$];
    logic [W-1:0] sb1 [$];

    always #5 clock = ~clock;

    queue_2x412 #(.WIDTH(W), .DEPTH(2), .FLOW(1'b0), .PIPE(1'b0)) u_q0 (
        .clock(clock), .reset(reset),
        .io_enq_valid(enq_valid), .io_enq_ready(enq_rdy[0]), .io_enq_bits(enq_bits),
        .io_deq_valid(deq_vld[0]), .io_deq_ready(deq_ready), .io_deq_bits(deq_bits[0]),
        .io_count(cnt[0]), .io_flush(flush)
    );

    queue_2x412 #(.WIDTH(W), .DEPTH(2), .FLOW(1'b1), .PIPE(1'b1)) u_q1 (
        .clock(clock), .reset(reset),
        .io_enq_valid(enq_valid), .io_enq_ready(enq_rdy[1]), .io_enq_bits(enq_bits),
        .io_deq_valid(deq_vld[1]), .io_deq_ready(deq_ready), .io_deq_bits(deq_bits[1]),
        .io_count(cnt[1]), .io_flush(flush)
    );

    // Reference model: queue 1 has FLOW and PIPE enabled, queue 0 has neither.
    function automatic bit has_flow(int id);
        return id == 1;
    endfunction

    function automatic bit has_pipe(int id);
        return id == 1;
    endfunction

    function automatic int sb_size(int id);
        return (id == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic logic [W-1:0] sb_head(int id);
        return (id == 0) ? sb0[0] : sb1[0];
    endfunction

    task automatic sb_push(int id, logic [W-1:0] v);
        if (id == 0) sb0.push_back(v);
        else         sb1.push_back(v);
    endtask

    task automatic sb_pop(int id);
        if (id == 0) void'(sb0.pop_front());
        else         void'(sb1.pop_front());
    endtask

    task automatic sb_clear(int id);
        if (id == 0) sb0.delete();
        else         sb1.delete();
    endtask

    function automatic logic [W-1:0] pat(logic [7:0] b);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = b[i % 8];
        return r;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [415:0] t;
        for (int i = 0; i < 13; i++) t[i*32 +: 32] = $urandom;
        return t[W-1:0];
    endfunction

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: occupancy before this cycle's push decides ready/valid/count.
    task automatic mon(int id);
        int n;
        bit exp_rdy;
        bit exp_vld;
        n       = sb_size(id) - (pushed[id] ? 1 : 0);
        exp_rdy = (n < 2) || (has_pipe(id) && deq_ready);
        exp_vld = (n > 0) || (has_flow(id) && enq_valid);
        check($sformatf("q%0d.count", id), W'(cnt[id]), W'(n));
        check($sformatf("q%0d.enq_ready", id), W'(enq_rdy[id]), W'(exp_rdy));
        check($sformatf("q%0d.deq_valid", id), W'(deq_vld[id]), W'(exp_vld));
        if (exp_vld && deq_ready && sb_size(id) > 0) begin
            check($sformatf("q%0d.deq_bits", id), deq_bits[id], sb_head(id));
            sb_pop(id);
        end
        if (reset || flush) sb_clear(id);
        pushed[id] = 1'b0;
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            for (int id = 0; id < 2; id++) mon(id);
        end
    end

    // Driver: one cycle of stimulus; expected payloads enter the scoreboard on acceptance.
    task automatic cyc(bit ev, logic [W-1:0] b, bit dr, bit fl, bit rs);
        int n;
        enq_valid = ev;
        enq_bits  = b;
        deq_ready = dr;
        flush     = fl;
        reset     = rs;
        #1;
        for (int id = 0; id < 2; id++) begin
            n = sb_size(id);
            if (ev && ((n < 2) || (has_pipe(id) && dr))) begin
                sb_push(id, b);
                pushed[id] = 1'b1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        flush     = 1'b0;
        enq_bits  = '0;
        pushed[0] = 1'b0;
        pushed[1] = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_en = 1'b1;

        // Idle after reset
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 1, 0, 0);

        // Fill to two, blocked third attempt, drain in order
        cyc(1, pat(8'hA5), 0, 0, 0);
        cyc(1, pat(8'h3C), 0, 0, 0);
        cyc(1, pat(8'hEE), 0, 0, 0);
        cyc(0, '0, 1, 0, 0);
        cyc(0, '0, 1, 0, 0);
        cyc(0, '0, 1, 0, 0);

        // Reset while full
        cyc(1, rnd(), 0, 0, 0);
        cyc(1, rnd(), 0, 0, 0);
        cyc(0, '0, 0, 0, 1);
        cyc(0, '0, 1, 0, 0);

        // Streaming 1..10 with both sides always active
        for (int i = 1; i <= 10; i++) cyc(1, W'(i), 1, 0, 0);
        cyc(0, '0, 1, 0, 0);
        cyc(0, '0, 1, 0, 0);

        // Same-cycle pass-through on an empty queue
        cyc(1, pat(8'h77), 1, 0, 0);
        cyc(0, '0, 0, 0, 0);

        // Enqueue into a full queue while dequeuing
        cyc(1, pat(8'h11), 0, 0, 0);
        cyc(1, pat(8'h22), 0, 0, 0);
        cyc(1, pat(8'h55), 1, 0, 0);
        cyc(0, '0, 1, 0, 0);
        cyc(0, '0, 1, 0, 0);
        cyc(0, '0, 1, 0, 0);

        // Flush with a concurrent enqueue, then reuse
        cyc(1, rnd(), 0, 0, 0);
        cyc(1, rnd(), 0, 0, 0);
        cyc(1, rnd(), 0, 1, 0);
        cyc(1, pat(8'h99), 0, 0, 0);
        cyc(0, '0, 1, 0, 0);
        cyc(0, '0, 1, 0, 0);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 2) != 0,
                $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
        end
        cyc(0, '0, 0, 0, 0);

        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/queue_2x412.md
# queue_2x412

Two-entry, 412-bit ready/valid FIFO controller that owns the write and read ports of the `ram_2x412` storage array. It sits directly upstream of the RAM:
- converts an enqueue/dequeue handshake pair into RAM write-enable, write-address and read-address;
- tracks occupancy with wrap-around pointers.

It is the standard decoupling buffer between adjacent core pipeline stages carrying 412-bit payloads.

## Interface
Parameters:
- WIDTH, 412: payload width in bits; must equal the RAM data width.
- DEPTH, 2: number of entries; power of two, ≥2.
- FLOW, 0: when 1, an empty queue passes enq data to deq in the same cycle.
- PIPE, 0: when 1, a full queue accepts an enqueue in the same cycle that it dequeues.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- io_enq_valid  in  1  producer offers io_enq_bits.
- io_enq_ready  out  1  queue can accept this cycle.
- io_enq_bits  in  WIDTH  enqueue payload.
- io_deq_valid  out  1  io_deq_bits holds the head entry.
- io_deq_ready  in  1  consumer takes the head this cycle.
- io_deq_bits  out  WIDTH  head payload; don't-care when io_deq_valid=0.
- io_count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- io_flush  in  1  discard all entries.

## Operation
- State:
  - enq_ptr and deq_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH;
  - maybe_full, 1 bit.
- Derived status:
  - ptr_match = (enq_ptr == deq_ptr)
  - empty = ptr_match & ~maybe_full
  - full = ptr_match & maybe_full
- io_enq_ready = ~full | (PIPE & io_deq_ready).
- io_deq_valid = ~empty | (FLOW & io_enq_valid).
- Fire signals: enq_fire = io_enq_valid & io_enq_ready; deq_fire = io_deq_valid & io_deq_ready.
- FLOW bypass (FLOW=1 & empty & enq_fire & deq_fire):
  - do_enq = do_deq = 0;
  - io_deq_bits = io_enq_bits;
  - no RAM write, no pointer move.
- Otherwise do_enq = enq_fire and do_deq = deq_fire.
- Write path: RAM W0_en = do_enq, W0_addr = enq_ptr, W0_data = io_enq_bits.
- Read path:
  - R0_en tied to 1, R0_addr = deq_ptr;
  - io_deq_bits = R0_data, except during the FLOW bypass case above.
- Register updates:
  - do_enq: enq_ptr <= enq_ptr + 1, wrapping DEPTH-1 → 0.
  - do_deq: deq_ptr <= deq_ptr + 1, same wrap.
  - do_enq != do_deq: maybe_full <= do_enq. Otherwise maybe_full holds.
- io_count:
  - full: io_count = DEPTH;
  - otherwise io_count = (enq_ptr - deq_ptr) mod DEPTH, zero-extended.
- io_flush:
  - next state is enq_ptr = deq_ptr = 0, maybe_full = 0;
  - overrides any same-cycle do_enq/do_deq pointer update;
  - a same-cycle RAM write still occurs but is unreachable;
  - handshake outputs in the flush cycle are still computed from current state.
- reset:
  - same next state as io_flush, with priority over everything;
  - RAM contents are not reset.

## Timing
- Reset values: enq_ptr = deq_ptr = 0, maybe_full = 0.
- Outputs after reset:
  - io_enq_ready = 1;
  - io_deq_valid = FLOW & io_enq_valid, i.e. 0 with default parameters;
  - io_count = 0.
- Enqueue-to-dequeue latency:
  - default: data written at edge N is visible on io_deq_bits with io_deq_valid = 1 in cycle N+1;
  - FLOW=1 on an empty queue: 0 cycles.
- All outputs are combinational from state and inputs; no output registers.
- Boundary cases:
  - Empty, no FLOW: a dequeue cannot fire.
  - Full, PIPE=0: an enqueue is blocked even if the consumer is dequeuing.
  - Full with simultaneous enq and deq (PIPE=1): both pointers advance; maybe_full stays 1; occupancy stays DEPTH.
  - Non-empty, non-full with simultaneous enq and deq: occupancy is unchanged.
  - Wrap-around: no special case; pointer arithmetic is modulo DEPTH.
- Handshake rules:
  - The producer must hold io_enq_bits stable while valid and not ready.
  - The queue holds io_deq_bits and io_deq_valid stable until deq_fire.
  - Exceptions: flush and reset may drop io_deq_valid without a handshake.

## Structure
- Shared package queue_pkg holds:
  - QUEUE_WIDTH = 412 and QUEUE_DEPTH = 2;
  - derived widths PTR_W = $clog2(DEPTH) and CNT_W = $clog2(DEPTH+1);
  - a typedef for the payload vector.
- One sub-module: the existing `ram_2x412` storage, instantiated as-is with R0_clk and W0_clk both tied to clock.
- Control logic (pointers, maybe_full, fire logic, count) lives in this module; no further hierarchy.

## Test plan
- Reset, then idle:
  - io_enq_ready = 1, io_deq_valid = 0, io_count = 0.
  - Assert reset again with the queue full: next cycle io_count = 0.
- Enqueue 0xA5…A5 then 0x3C…3C, with io_deq_ready = 0:
  - io_count goes 1 → 2; io_enq_ready = 0 at count 2;
  - a third enqueue attempt is not accepted;
  - after deq_ready = 1: deq order is A5 then 3C.
- Streaming with enq_valid = deq_ready = 1 for 10 cycles, incrementing payload 1..10:
  - deq sees 1..10 in order with no gaps after the first cycle;
  - pointers wrap at least 4 times;
  - io_count stays 1.
- FLOW=1, empty queue, enq_valid = 1 with payload 0x77, deq_ready = 1:
  - same-cycle io_deq_valid = 1 and io_deq_bits = 0x77;
  - next cycle io_count = 0 and no RAM write occurred.
- PIPE=1, full queue, simultaneous enq of 0x55 and deq:
  - head leaves, 0x55 is accepted, io_count stays 2;
  - 0x55 emerges after the older entry.
- Queue holding 2 entries, io_flush pulsed together with enq_valid = 1:
  - next cycle io_count = 0, io_deq_valid = 0;
  - a subsequent enqueue of 0x99 dequeues as 0x99.
